apb_master_bridge: RTL
======================

Name: apb_master_bridge

Overview:
Upstream neighbour of the APB register slave. Accepts simple single-beat command requests from a local initiator (testbench sequencer, CPU-side shim) and converts each into one APB SETUP/ACCESS transfer. Waits for pready and returns read data or error status on a response pulse. Holds pwrite low whenever idle, because the slave decodes pwrite/paddr every cycle.

Parameters:
ADDR_W, 5, APB address width (paddr[4:2] selects one of the slave's registers)
DATA_W, 8, APB data width
TIMEOUT, 15, maximum ACCESS-phase wait cycles before the transfer is aborted with error

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  bridge can accept a command (high only in IDLE)
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  target byte address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  read data (0 for writes and errors)
rsp_err  out  1  transfer timed out
psel  out  1  APB select
penable  out  1  APB access phase
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
prdata  in  DATA_W  APB read data
pready  in  1  APB ready (tie to 1 for zero-wait slaves)

Behaviour:
- Reset (async, immediate): state IDLE; psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err all 0; wait counter 0; cmd_ready 1 once reset is released. An in-flight transfer is dropped and produces no response.
- FSM states: IDLE, SETUP, ACCESS. All APB outputs and response outputs are registered.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch write/addr/wdata and go to SETUP.
  - pwrite = 0 and psel = 0 in IDLE; paddr and pwdata hold their last values.
- SETUP (exactly 1 cycle):
  - psel = 1, penable = 0; paddr, pwrite, pwdata driven from the latched command.
  - Clear the wait counter, then go to ACCESS.
- ACCESS:
  - psel = 1, penable = 1; address, direction and data held stable.
  - If pready = 1: next cycle rsp_valid = 1, rsp_err = 0, rsp_rdata = prdata for reads (sampled this cycle) or 0 for writes. Drop psel, penable and pwrite. Go to IDLE.
  - If pready = 0: increment the wait counter. When the counter equals TIMEOUT, end the transfer the same way but with rsp_err = 1 and rsp_rdata = 0.
- Latency:
  - Handshake in cycle N; SETUP at N+1; ACCESS at N+2; with pready = 1, rsp_valid at N+3.
  - cmd_ready rises again at N+3, so back-to-back throughput is one transfer per 3 cycles.
  - Each pready wait cycle adds 1.
- rsp_valid is a single-cycle pulse with no backpressure. rsp_rdata and rsp_err hold their values until the next response.
- A read against the synchronous-prdata slave is correct: the slave registers prdata at the end of SETUP, and the bridge samples it at the end of ACCESS.
- cmd_* inputs are ignored outside IDLE. A cmd_valid held across a response is accepted on the cycle cmd_ready is high.
- Counter width is clog2(TIMEOUT+1). A TIMEOUT of 0 means an error on the first unready ACCESS cycle.

Decomposition:
- Shared package apb_pkg:
  - state enum {IDLE, SETUP, ACCESS};
  - ADDR_W/DATA_W defaults;
  - register offset constants CTRL = 0x00, REG1 = 0x04, REG2 = 0x08, REG3 = 0x0C, REG4 = 0x10 (also used by the slave and bench).
- Single module; no sub-module needed. The wait counter stays inline.

Test Plan:
- Write then read: cmd write addr 0x04 data 0xA5, then read 0x04, pready = 1 -> pwrite high only during SETUP/ACCESS; read rsp_rdata = 0xA5, rsp_err = 0, rsp_valid exactly 3 cycles after each handshake.
- All registers: write 0x11, 0x22, 0x33, 0x44, 0x55 to 0x00..0x10 back-to-back with cmd_valid held -> one transfer per 3 cycles; readback matches each value.
- Wait states: pready held low 4 ACCESS cycles on a read of 0x08 -> psel/penable/paddr stable throughout; rsp_valid 7 cycles after handshake with correct data.
- Timeout: pready held 0, TIMEOUT = 15 -> rsp_err = 1, rsp_rdata = 0 after 15 wait cycles; bridge returns to IDLE and the next command completes normally.
- Reset mid-ACCESS: assert rst asynchronously during ACCESS -> psel, penable, pwrite and rsp_valid go 0 immediately, with no response pulse; a post-reset read of 0x00 returns 0.
- Idle hygiene: no commands for 20 cycles -> pwrite = 0 and psel = 0 throughout; slave registers unchanged.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB bridge, slave and bench.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 8;

  // Register byte offsets; paddr[4:2] picks the register.
  localparam logic [4:0] CTRL = 5'h00;
  localparam logic [4:0] REG1 = 5'h04;
  localparam logic [4:0] REG2 = 5'h08;
  localparam logic [4:0] REG3 = 5'h0C;
  localparam logic [4:0] REG4 = 5'h10;

  // Wait-counter width; at least one bit so TIMEOUT = 0 still has a counter.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/apb_master_bridge.sv
// Single-beat command to APB SETUP/ACCESS bridge with pready timeout.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  localparam int unsigned CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              psel_n, penable_n, pwrite_n;
  logic [ADDR_W-1:0] paddr_n;
  logic [DATA_W-1:0] pwdata_n;
  logic              rsp_valid_n, rsp_err_n;
  logic [DATA_W-1:0] rsp_rdata_n;

  assign cmd_ready = (state == IDLE);

  // State, APB outputs and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      psel      <= psel_n;
      penable   <= penable_n;
      pwrite    <= pwrite_n;
      paddr     <= paddr_n;
      pwdata    <= pwdata_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_err   <= rsp_err_n;
    end
  end

  // Next-state and next-output logic. The APB address/data registers double
  // as the command latch: they load at the handshake and hold through IDLE.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    psel_n      = psel;
    penable_n   = penable;
    pwrite_n    = pwrite;
    paddr_n     = paddr;
    pwdata_n    = pwdata;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = rsp_rdata;
    rsp_err_n   = rsp_err;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_n   = SETUP;
          psel_n    = 1'b1;
          penable_n = 1'b0;
          pwrite_n  = cmd_write;
          paddr_n   = cmd_addr;
          pwdata_n  = cmd_wdata;
        end
      end
      SETUP: begin
        state_n   = ACCESS;
        penable_n = 1'b1;
        cnt_n     = '0;
      end
      ACCESS: begin
        if (pready || (cnt == TMO)) begin
          state_n     = IDLE;
          psel_n      = 1'b0;
          penable_n   = 1'b0;
          pwrite_n    = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_err_n   = !pready;
          rsp_rdata_n = (pready && !pwrite) ? prdata : '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n   = IDLE;
        psel_n    = 1'b0;
        penable_n = 1'b0;
        pwrite_n  = 1'b0;
      end
    endcase
  end

endmodule
